// File: rtl/aq_djpeg_pkg.sv
// Shared definitions for the aq_djpeg IDCT datapath: widths, descale shift,
// column-read address layout and the pair-to-row mapping tables.
package aq_djpeg_pkg;

  localparam int IDCT_IN_W  = 32;
  localparam int IDCT_OUT_W = 16;
  localparam int IDCT_SHIFT = 10;

  typedef struct packed {
    logic [2:0] page;
    logic [1:0] pair;
  } idct_addr_t;

  // Rows delivered as (A, B) for each pair index k of a column read
  localparam logic [2:0] IDCT_PAIR_A [4] = '{3'd0, 3'd2, 3'd1, 3'd5};
  localparam logic [2:0] IDCT_PAIR_B [4] = '{3'd4, 3'd6, 3'd7, 3'd3};

endpackage

// File: rtl/aq_djpeg_idct_descale.sv
// Combinational round-to-nearest descale of a signed row-pass result,
// saturated to the signed OUT_W range.
module aq_djpeg_idct_descale #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 16,
  parameter int SHIFT = 10
) (
  input  logic [IN_W-1:0]  data_i,
  output logic [OUT_W-1:0] data_o
);

  // One guard bit keeps the rounding add from wrapping at the positive limit
  localparam logic signed [IN_W:0] ROUND = (IN_W+1)'(64'sd1 <<< (SHIFT - 1));
  localparam logic signed [IN_W:0] MAX_V = (IN_W+1)'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  localparam logic signed [IN_W:0] MIN_V = (IN_W+1)'(-(64'sd1 <<< (OUT_W - 1)));

  logic signed [IN_W:0] sum_s;
  logic signed [IN_W:0] shr_s;

  always_comb begin
    sum_s  = $signed({data_i[IN_W-1], data_i}) + ROUND;
    shr_s  = sum_s >>> SHIFT;
    data_o = shr_s[OUT_W-1:0];
    if (shr_s > MAX_V) begin
      data_o = MAX_V[OUT_W-1:0];
    end else if (shr_s < MIN_V) begin
      data_o = MIN_V[OUT_W-1:0];
    end else begin
      data_o = shr_s[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/aq_djpeg_idct_transpose.sv
// Ping-pong transpose buffer between the row and column IDCT passes:
// stores descaled row results, then serves each full bank in column order.
module aq_djpeg_idct_transpose
  import aq_djpeg_pkg::*;
#(
  parameter int IN_W  = IDCT_IN_W,
  parameter int OUT_W = IDCT_OUT_W,
  parameter int SHIFT = IDCT_SHIFT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             WrEnable,
  input  logic [2:0]       WrPage,
  input  logic [1:0]       WrCount,
  input  logic [IN_W-1:0]  WrData0,
  input  logic [IN_W-1:0]  WrData1,
  output logic             RdEnable,
  input  logic             RdRead,
  input  logic [4:0]       RdAddress,
  output logic [OUT_W-1:0] RdDataA,
  output logic [OUT_W-1:0] RdDataB,
  output logic [1:0]       BankFull,
  output logic             Overflow
);

  logic [OUT_W-1:0] mem_q [2][64];

  logic [OUT_W-1:0] desc0_s, desc1_s;
  logic [5:0]       wr_idx0_s, wr_idx1_s;
  logic             first_beat_s, last_beat_s, wr_accept_s;
  logic             rd_ok_s;
  idct_addr_t       rd_addr_s;
  logic [5:0]       rd_idx_a_s, rd_idx_b_s;

  logic             wr_bank_q, wr_bank_d;
  logic             rd_bank_q, rd_bank_d;
  logic [1:0]       full_q, full_d;
  logic             busy_q, busy_d;
  logic             drop_q, drop_d;
  logic             ovf_q, ovf_d;
  logic             rd_en_q, rd_en_d;
  logic [OUT_W-1:0] rd_a_q, rd_a_d;
  logic [OUT_W-1:0] rd_b_q, rd_b_d;

  aq_djpeg_idct_descale #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT)) u_desc0 (
    .data_i (WrData0),
    .data_o (desc0_s)
  );

  aq_djpeg_idct_descale #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT)) u_desc1 (
    .data_i (WrData1),
    .data_o (desc1_s)
  );

  // Element 7-c of a row is {1, ~c} within the row for c in 0..3
  assign wr_idx0_s    = {WrPage, 1'b0, WrCount};
  assign wr_idx1_s    = {WrPage, 1'b1, ~WrCount};
  assign first_beat_s = WrEnable && (WrPage == 3'd0) && (WrCount == 2'd0);
  assign last_beat_s  = (WrPage == 3'd7) && (WrCount == 2'd3);

  assign rd_addr_s  = RdAddress;
  assign rd_idx_a_s = {IDCT_PAIR_A[rd_addr_s.pair], rd_addr_s.page};
  assign rd_idx_b_s = {IDCT_PAIR_B[rd_addr_s.pair], rd_addr_s.page};
  // A read strobe is honoured only once RdEnable has been presented
  assign rd_ok_s    = RdRead && (rd_en_q || busy_q);

  always_comb begin
    drop_d      = drop_q;
    ovf_d       = ovf_q;
    wr_accept_s = 1'b0;
    full_d      = full_q;
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    busy_d      = busy_q;
    rd_a_d      = rd_a_q;
    rd_b_d      = rd_b_q;

    if (first_beat_s) begin
      if (full_q[wr_bank_q]) begin
        drop_d = 1'b1;
        ovf_d  = 1'b1;
      end else begin
        drop_d      = 1'b0;
        wr_accept_s = 1'b1;
      end
    end else if (WrEnable) begin
      wr_accept_s = !drop_q;
    end else begin
      wr_accept_s = 1'b0;
    end

    if (wr_accept_s && last_beat_s) begin
      full_d[wr_bank_q] = 1'b1;
      wr_bank_d         = ~wr_bank_q;
    end else begin
      wr_bank_d = wr_bank_q;
    end

    if (rd_ok_s) begin
      rd_a_d = mem_q[rd_bank_q][rd_idx_a_s];
      rd_b_d = mem_q[rd_bank_q][rd_idx_b_s];
      if (RdAddress == 5'd0) begin
        busy_d = 1'b1;
      end else if (RdAddress == 5'd31) begin
        busy_d            = 1'b0;
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = ~rd_bank_q;
      end else begin
        busy_d = busy_q;
      end
    end else begin
      busy_d = busy_q;
    end

    rd_en_d = full_d[rd_bank_d] && !busy_d;
  end

  // Control and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      full_q    <= 2'b00;
      busy_q    <= 1'b0;
      drop_q    <= 1'b0;
      ovf_q     <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_a_q    <= '0;
      rd_b_q    <= '0;
    end else begin
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      full_q    <= full_d;
      busy_q    <= busy_d;
      drop_q    <= drop_d;
      ovf_q     <= ovf_d;
      rd_en_q   <= rd_en_d;
      rd_a_q    <= rd_a_d;
      rd_b_q    <= rd_b_d;
    end
  end

  // Block storage keeps its contents across reset
  always_ff @(posedge clk) begin
    if (wr_accept_s) begin
      mem_q[wr_bank_q][wr_idx0_s] <= desc0_s;
      mem_q[wr_bank_q][wr_idx1_s] <= desc1_s;
    end
  end

  assign RdEnable = rd_en_q;
  assign RdDataA  = rd_a_q;
  assign RdDataB  = rd_b_q;
  assign BankFull = full_q;
  assign Overflow = ovf_q;

endmodule

// File: tb/tb_aq_djpeg_idct_transpose.sv
// Scoreboard bench for the IDCT transpose buffer: directed blocks and column
// reads with hand-computed expected pairs, checked by a separate monitor.
module tb_aq_djpeg_idct_transpose;

  logic        clk = 1'b0;
  logic        rst;
  logic        WrEnable;
  logic [2:0]  WrPage;
  logic [1:0]  WrCount;
  logic [31:0] WrData0, WrData1;
  logic        RdEnable;
  logic        RdRead;
  logic [4:0]  RdAddress;
  logic [15:0] RdDataA, RdDataB;
  logic [1:0]  BankFull;
  logic        Overflow;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];
  logic        rd_fire_q;

  aq_djpeg_idct_transpose dut (
    .clk(clk), .rst(rst), .WrEnable(WrEnable), .WrPage(WrPage), .WrCount(WrCount),
    .WrData0(WrData0), .WrData1(WrData1), .RdEnable(RdEnable), .RdRead(RdRead),
    .RdAddress(RdAddress), .RdDataA(RdDataA), .RdDataB(RdDataB),
    .BankFull(BankFull), .Overflow(Overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) rd_fire_q <= 1'b0;
    else     rd_fire_q <= RdRead;
  end

  // Monitor: each accepted read strobe yields one data pair by the next negedge
  always @(negedge clk) begin
    if (rd_fire_q) begin
      logic [31:0] e;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL rd_data: unexpected pair A=%h B=%h", RdDataA, RdDataB);
      end else begin
        e = exp_q.pop_front();
        if ({RdDataA, RdDataB} !== e)
          begin
            bad++;
            $display("FAIL rd_data: got A=%h B=%h want A=%h B=%h", RdDataA, RdDataB, e[31:16], e[15:0]);
          end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic rd(input int j, input int k, input logic [15:0] ea, input logic [15:0] eb);
    exp_q.push_back({ea, eb});
    RdRead    = 1'b1;
    RdAddress = 5'((j << 2) | k);
    tick();
    RdRead    = 1'b0;
  endtask

  // mode 0: X[r][c] = base + 8r + c (pre-scaled); mode 1: descale corner values
  task automatic write_block(input int base, input int mode, input bit rel, input int nbeats);
    int n = 0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (n < nbeats) begin
          logic [31:0] d0, d1;
          d0 = 32'((base + 8*r + c) << 10);
          d1 = 32'((base + 8*r + 7 - c) << 10);
          if (mode == 1) begin
            d0 = 32'h0; d1 = 32'h0;
            if (r == 0 && c == 0) begin d0 = 32'h0000_01FF; d1 = 32'h0000_0200; end
            if (r == 4 && c == 0) begin d0 = 32'hFFFF_FE00; d1 = 32'hFFFF_FDFF; end
            if (r == 0 && c == 1) begin d0 = 32'h7FFF_FFFF; d1 = 32'h8000_0000; end
          end
          if (rel && r == 7 && c == 3) begin
            RdRead    = 1'b1;
            RdAddress = 5'd31;
          end
          WrEnable = 1'b1;
          WrPage   = 3'(r);
          WrCount  = 2'(c);
          WrData0  = d0;
          WrData1  = d1;
          tick();
          WrEnable = 1'b0;
          RdRead   = 1'b0;
        end
        n++;
      end
    end
  endtask

  initial begin
    rst = 1'b1; WrEnable = 1'b0; WrPage = 3'd0; WrCount = 2'd0;
    WrData0 = 32'h0; WrData1 = 32'h0; RdRead = 1'b0; RdAddress = 5'd0;
    #12 rst = 1'b0;
    tick();

    // Reset mid-block with live state
    write_block(50, 0, 1'b0, 32);
    rd(1, 2, 16'd59, 16'd107);
    write_block(50, 0, 1'b0, 5);
    #2 rst = 1'b1;
    #1;
    check("rst_rdenable", {31'd0, RdEnable}, 32'd0);
    check("rst_bankfull", {30'd0, BankFull}, 32'd0);
    check("rst_rddata",   {RdDataA, RdDataB}, 32'd0);
    check("rst_overflow", {31'd0, Overflow}, 32'd0);
    #3 rst = 1'b0;
    tick();

    // Mapping and handshake
    write_block(0, 0, 1'b0, 32);
    check("map_bankfull", {30'd0, BankFull}, 32'd1);
    check("map_rdenable", {31'd0, RdEnable}, 32'd1);
    rd(0, 0, 16'd0, 16'd32);
    check("hs_busy_rdenable", {31'd0, RdEnable}, 32'd0);
    rd(1, 2, 16'd9, 16'd57);
    rd(6, 3, 16'd46, 16'd30);
    write_block(100, 0, 1'b0, 32);
    check("hs_both_full", {30'd0, BankFull}, 32'd3);
    rd(7, 3, 16'd47, 16'd31);
    check("hs_release_bankfull", {30'd0, BankFull}, 32'd2);
    check("hs_release_rdenable", {31'd0, RdEnable}, 32'd1);
    rd(0, 0, 16'd100, 16'd132);
    rd(7, 3, 16'd147, 16'd131);
    check("hs_empty_bankfull", {30'd0, BankFull}, 32'd0);
    check("hs_empty_rdenable", {31'd0, RdEnable}, 32'd0);

    // Descale rounding and saturation
    write_block(0, 1, 1'b0, 32);
    check("desc_rdenable", {31'd0, RdEnable}, 32'd1);
    rd(0, 0, 16'h0000, 16'h0000);
    rd(7, 0, 16'h0001, 16'hFFFF);
    rd(1, 0, 16'h7FFF, 16'h0000);
    rd(6, 0, 16'h8000, 16'h0000);
    rd(7, 3, 16'h0000, 16'h0000);

    // Overflow: third block with no reads is discarded
    write_block(200, 0, 1'b0, 32);
    check("ovf_b1_bankfull", {30'd0, BankFull}, 32'd2);
    write_block(300, 0, 1'b0, 32);
    check("ovf_b2_bankfull", {30'd0, BankFull}, 32'd3);
    check("ovf_b2_overflow", {31'd0, Overflow}, 32'd0);
    write_block(400, 0, 1'b0, 32);
    check("ovf_b3_bankfull", {30'd0, BankFull}, 32'd3);
    check("ovf_b3_overflow", {31'd0, Overflow}, 32'd1);
    rd(0, 0, 16'd200, 16'd232);
    rd(1, 2, 16'd209, 16'd257);
    rd(7, 3, 16'd247, 16'd231);
    check("ovf_rel_bankfull", {30'd0, BankFull}, 32'd1);
    rd(0, 0, 16'd300, 16'd332);

    // Concurrency: completion into bank1 while bank0 releases
    exp_q.push_back({16'd347, 16'd331});
    write_block(500, 0, 1'b1, 32);
    check("conc_bankfull", {30'd0, BankFull}, 32'd2);
    check("conc_rdenable", {31'd0, RdEnable}, 32'd1);
    check("conc_overflow", {31'd0, Overflow}, 32'd1);
    rd(0, 0, 16'd500, 16'd532);
    rd(1, 2, 16'd509, 16'd557);

    tick();
    tick();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
